ahb_mtx_out_arb: RTL and testbench

//   Output-stage arbiter for the AHB bus matrix: shares one output port (master interface MI0) between
//   NUM_PORTS input-stage decoders. Grants round-robin and holds the grant across fixed-length bursts
//   and locked sequences. Drives the per-port active signals back to the decoders and the registered

---
 rtl/ahb_mtx_out_arb.sv | 141 ++++++++++++++
 tb/tb_ahb_mtx_out_arb.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/ahb_mtx_out_arb.sv
// Output-stage arbiter for one bus-matrix output port: round-robin grant with hold
// across fixed-length bursts, undefined-length SEQ/BUSY runs and locked sequences.
module ahb_mtx_out_arb #(
    parameter int NUM_PORTS = 3,
    parameter int PORT_W    = 2
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic                   HREADYM,
    input  logic [NUM_PORTS-1:0]   sel_req,
    input  logic [2*NUM_PORTS-1:0] trans_in,
    input  logic [3*NUM_PORTS-1:0] burst_in,
    input  logic [NUM_PORTS-1:0]   lock_in,
    output logic [PORT_W-1:0]      addr_in_port,
    output logic                   no_port,
    output logic [PORT_W-1:0]      data_in_port,
    output logic                   data_valid,
    output logic [NUM_PORTS-1:0]   active_arb
);

    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_BUSY   = 2'b01;
    localparam logic [1:0] HT_NONSEQ = 2'b10;
    localparam logic [1:0] HT_SEQ    = 2'b11;

    logic [PORT_W-1:0]    r_addr_port, r_data_port, r_last_grant;
    logic                 r_no_port, r_data_valid;
    logic [3:0]           r_beat_cnt;

    logic [NUM_PORTS-1:0] w_req;
    logic [1:0]           w_own_trans;
    logic [2:0]           w_own_burst;
    logic                 w_own_lock;
    logic                 w_found;
    logic [PORT_W-1:0]    w_winner;
    logic [3:0]           w_burst_len;
    logic [3:0]           w_cnt_nxt;
    logic                 w_fixed, w_hold;
    logic [PORT_W-1:0]    w_addr_nxt, w_last_nxt;
    logic                 w_no_port_nxt;
    logic [3:0]           w_beat_nxt;

    // Owner's controls and the per-port NONSEQ requests.
    always_comb begin
        w_own_trans = HT_IDLE;
        w_own_burst = 3'b000;
        w_own_lock  = 1'b0;
        w_req       = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_req[i] = sel_req[i] & (trans_in[2*i +: 2] == HT_NONSEQ);
            if (r_addr_port == PORT_W'(i)) begin
                w_own_trans = trans_in[2*i +: 2];
                w_own_burst = burst_in[3*i +: 3];
                w_own_lock  = lock_in[i];
            end
        end
    end

    // Round-robin: position k after last_grant is port (last_grant + k) mod NUM_PORTS.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_addr_port;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (!w_found && w_req[i] &&
                    (r_last_grant == PORT_W'((i + NUM_PORTS - k) % NUM_PORTS))) begin
                    w_found  = 1'b1;
                    w_winner = PORT_W'(i);
                end
            end
        end
    end

    // Beat counter holds the beats still to come after the current one, so a
    // fixed burst is released on the edge that accepts its last beat.
    always_comb begin
        case (w_own_burst)
            3'b010, 3'b011: w_burst_len = 4'd3;
            3'b100, 3'b101: w_burst_len = 4'd7;
            3'b110, 3'b111: w_burst_len = 4'd15;
            default:        w_burst_len = 4'd0;
        endcase
        case (w_own_trans)
            HT_NONSEQ: w_cnt_nxt = w_burst_len;
            HT_SEQ:    w_cnt_nxt = (r_beat_cnt == 4'd0) ? 4'd0 : r_beat_cnt - 4'd1;
            HT_BUSY:   w_cnt_nxt = r_beat_cnt;
            default:   w_cnt_nxt = 4'd0;
        endcase
        w_fixed = (w_own_trans == HT_NONSEQ) ? (w_burst_len != 4'd0) : (r_beat_cnt != 4'd0);
        // Undefined-length bursts hold while the owner keeps issuing SEQ/BUSY.
        w_hold  = ~r_no_port & (w_own_lock | (w_fixed ? (w_cnt_nxt != 4'd0) : w_own_trans[0]));
    end

    always_comb begin
        w_addr_nxt    = r_addr_port;
        w_last_nxt    = r_last_grant;
        w_no_port_nxt = r_no_port;
        w_beat_nxt    = r_beat_cnt;
        if (w_hold) begin
            w_beat_nxt = w_cnt_nxt;
        end else if (w_found) begin
            w_addr_nxt    = w_winner;
            w_last_nxt    = w_winner;
            w_no_port_nxt = 1'b0;
            w_beat_nxt    = 4'd0;
        end else begin
            w_no_port_nxt = 1'b1;
            w_beat_nxt    = 4'd0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_addr_port  <= '0;
            r_no_port    <= 1'b1;
            r_data_port  <= '0;
            r_data_valid <= 1'b0;
            r_beat_cnt   <= 4'd0;
            r_last_grant <= PORT_W'(NUM_PORTS - 1);
        end else if (HREADYM) begin
            r_addr_port  <= w_addr_nxt;
            r_no_port    <= w_no_port_nxt;
            r_last_grant <= w_last_nxt;
            r_beat_cnt   <= w_beat_nxt;
            r_data_port  <= r_addr_port;
            r_data_valid <= ~r_no_port & w_own_trans[1];
        end
    end

    always_comb begin
        active_arb = '0;
        for (int i = 0; i < NUM_PORTS; i++)
            active_arb[i] = ~r_no_port & (r_addr_port == PORT_W'(i));
    end

    assign addr_in_port = r_addr_port;
    assign no_port      = r_no_port;
    assign data_in_port = r_data_port;
    assign data_valid   = r_data_valid;

endmodule

// File: tb/tb_ahb_mtx_out_arb.sv
// Directed bench for ahb_mtx_out_arb: reset, lone request, fairness, burst hold
// with stalls, reset mid-burst, lock and early burst termination.
module tb_ahb_mtx_out_arb;

    localparam logic [1:0] IDLE = 2'b00, NSQ = 2'b10, SEQ = 2'b11;
    localparam logic [2:0] SGL = 3'b000, INCR4 = 3'b011, INCR8 = 3'b101;

    logic       HCLK = 1'b0;
    logic       HRESETn, HREADYM;
    logic [2:0] sel_req, lock_in;
    logic [1:0] tr [3];
    logic [2:0] bu [3];
    logic [5:0] trans_in;
    logic [8:0] burst_in;
    logic [1:0] addr_in_port, data_in_port;
    logic       no_port, data_valid;
    logic [2:0] active_arb;
    int         n_cmp = 0;
    int         n_bad = 0;

    assign trans_in = {tr[2], tr[1], tr[0]};
    assign burst_in = {bu[2], bu[1], bu[0]};

    always #5 HCLK = ~HCLK;

    ahb_mtx_out_arb #(.NUM_PORTS(3), .PORT_W(2)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HREADYM(HREADYM),
        .sel_req(sel_req), .trans_in(trans_in), .burst_in(burst_in), .lock_in(lock_in),
        .addr_in_port(addr_in_port), .no_port(no_port), .data_in_port(data_in_port),
        .data_valid(data_valid), .active_arb(active_arb)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic [1:0] p, input logic s, input logic [1:0] t,
                       input logic [2:0] b, input logic l);
        sel_req[p] = s;
        tr[p]      = t;
        bu[p]      = b;
        lock_in[p] = l;
    endtask

    task automatic clear_all();
        for (int i = 0; i < 3; i++) drv(2'(i), 1'b0, IDLE, SGL, 1'b0);
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic do_reset();
        HRESETn = 1'b0;
        tick();
        HRESETn = 1'b1;
    endtask

    initial begin
        HREADYM = 1'b1;
        HRESETn = 1'b0;
        sel_req = '0;
        lock_in = '0;
        clear_all();
        #12;
        chk("rst_no_port", no_port, 1);
        chk("rst_active", active_arb, 0);
        chk("rst_data_valid", data_valid, 0);
        chk("rst_addr", addr_in_port, 0);
        chk("rst_data_port", data_in_port, 0);
        HRESETn = 1'b1;

        // Lone request from port 1
        drv(1, 1, NSQ, SGL, 0);
        tick();
        chk("lone_grant", active_arb, 3'b010);
        chk("lone_addr", addr_in_port, 1);
        chk("lone_dv0", data_valid, 0);
        tick();
        chk("lone_dport", data_in_port, 1);
        chk("lone_dv1", data_valid, 1);
        drv(1, 0, IDLE, SGL, 0);
        tick();
        chk("lone_release", no_port, 1);
        chk("lone_active0", active_arb, 0);
        chk("lone_addr_kept", addr_in_port, 1);
        chk("lone_dv_idle", data_valid, 0);

        // Fairness: every port issues NONSEQ SINGLE every cycle
        do_reset();
        for (int i = 0; i < 3; i++) drv(2'(i), 1, NSQ, SGL, 0);
        tick(); chk("rr_g1", active_arb, 3'b001); chk("rr_dv1", data_valid, 0);
        tick(); chk("rr_g2", active_arb, 3'b010); chk("rr_dp2", data_in_port, 0);
        tick(); chk("rr_g3", active_arb, 3'b100); chk("rr_dp3", data_in_port, 1);
        tick(); chk("rr_g4", active_arb, 3'b001); chk("rr_dp4", data_in_port, 2);
        tick(); chk("rr_g5", active_arb, 3'b010);
        tick(); chk("rr_g6", active_arb, 3'b100);

        // Burst hold: port0 INCR4 while port2 waits, with a 3-cycle stall
        clear_all();
        do_reset();
        drv(0, 1, NSQ, INCR4, 0);
        drv(2, 1, NSQ, SGL, 0);
        tick(); chk("bh_grant", active_arb, 3'b001);
        tick(); chk("bh_beat1", active_arb, 3'b001);
        drv(0, 1, SEQ, INCR4, 0);
        tick(); chk("bh_beat2", active_arb, 3'b001);
        HREADYM = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tick();
            chk("bh_stall_act", active_arb, 3'b001);
            chk("bh_stall_dp", data_in_port, 0);
            chk("bh_stall_dv", data_valid, 1);
        end
        HREADYM = 1'b1;
        tick(); chk("bh_beat3", active_arb, 3'b001);
        tick(); chk("bh_beat4_rel", active_arb, 3'b100);
        chk("bh_addr2", addr_in_port, 2);

        // Reset mid-burst: port2 in an INCR8 while ports 0/1 wait
        drv(0, 1, NSQ, SGL, 0);
        drv(1, 1, NSQ, SGL, 0);
        drv(2, 1, NSQ, INCR8, 0);
        tick(); chk("rm_hold", active_arb, 3'b100);
        drv(2, 1, SEQ, INCR8, 0);
        tick(); chk("rm_hold2", active_arb, 3'b100);
        #2 HRESETn = 1'b0;
        #1;
        chk("rm_no_port", no_port, 1);
        chk("rm_active", active_arb, 0);
        chk("rm_dv", data_valid, 0);
        chk("rm_addr", addr_in_port, 0);
        tick();
        HRESETn = 1'b1;
        drv(2, 1, NSQ, SGL, 0);
        tick(); chk("rm_first_p0", active_arb, 3'b001);

        // Lock: port1 locked with an IDLE gap while port0 waits
        clear_all();
        do_reset();
        drv(1, 1, NSQ, SGL, 1);
        tick(); chk("lk_grant", active_arb, 3'b010);
        drv(0, 1, NSQ, SGL, 0);
        tick(); chk("lk_hold1", active_arb, 3'b010);
        drv(1, 0, IDLE, SGL, 1);
        tick(); chk("lk_idle_hold", active_arb, 3'b010); chk("lk_idle_dv", data_valid, 0);
        drv(1, 1, NSQ, SGL, 1);
        tick(); chk("lk_hold3", active_arb, 3'b010);
        drv(1, 0, IDLE, SGL, 0);
        drv(2, 1, NSQ, SGL, 0);
        tick(); chk("lk_rel_p2", active_arb, 3'b100);
        tick(); chk("lk_next_p0", active_arb, 3'b001);

        // Early termination: port0 INCR8 ERROR at beat 3 then IDLE; port1 waits
        clear_all();
        do_reset();
        drv(0, 1, NSQ, INCR8, 0);
        drv(1, 1, NSQ, SGL, 0);
        tick(); chk("et_grant", active_arb, 3'b001);
        tick(); chk("et_beat1", active_arb, 3'b001);
        drv(0, 1, SEQ, INCR8, 0);
        tick(); chk("et_beat2", active_arb, 3'b001);
        HREADYM = 1'b0;
        tick(); chk("et_err1", active_arb, 3'b001);
        HREADYM = 1'b1;
        drv(0, 0, IDLE, INCR8, 0);
        tick();
        chk("et_p1_grant", active_arb, 3'b010);
        chk("et_dv", data_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
